// File: rtl/tt_pin_reg_responder.sv
// tt_pin_reg_responder: host-driven pin protocol responder for a trim register bank.
// Optional auto-increment of the data-phase address: define TT_PIN_REG_AUTOINC_EN.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   ui_in     host data / address byte
//   uio_in    [0]=stb [1]=rnw [2]=is_addr, [7:3] ignored
//   uo_out    registered read data
//   uio_out   [3]=ack [4]=err, other bits 0
//   uio_oe    pad output enables (8'h18 once out of reset)
//   status_in live status byte, readable at STATUS_ADDR
//   trim_out  flattened register bank, reg k at [8k+7:8k]
module tt_pin_reg_responder #(
    parameter int         NREGS       = 8,
    parameter logic [7:0] STATUS_ADDR = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         ui_in,
    input  logic [7:0]         uio_in,
    output logic [7:0]         uo_out,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe,
    input  logic [7:0]         status_in,
    output logic [NREGS*8-1:0] trim_out
);

    localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [8:0] NREGS_W = 9'(NREGS);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT_LO
    } state_t;

    state_t        state;
    logic [7:0]    regs [NREGS];
    logic [7:0]    addr;
    logic [7:0]    rd_data;
    logic          s1;
    logic          s2;
    logic          ack;
    logic          err;
    logic [7:0]    oe;

    logic          stb;
    logic          rnw;
    logic          is_addr;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [7:0]    addr_inc;

    assign stb      = uio_in[0];
    assign rnw      = uio_in[1];
    assign is_addr  = uio_in[2];
    assign in_range = ({1'b0, addr} < NREGS_W);
    assign idx      = addr[AW-1:0];
    assign addr_inc = ({1'b0, addr} == NREGS_W - 9'd1) ? 8'h00 : addr + 8'h01;

    assign uo_out  = rd_data;
    assign uio_out = {3'b000, err, ack, 3'b000};
    assign uio_oe  = oe;

    for (genvar k = 0; k < NREGS; k++) begin : g_trim
        assign trim_out[8*k +: 8] = regs[k];
    end

    // The transfer commits on the edge that enters EXEC, so the result
    // and ack become visible together two edges after s1 first sees stb.
    // EXEC is then a one-cycle hold before waiting for stb to drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= 8'h00;
            rd_data <= 8'h00;
            s1      <= 1'b0;
            s2      <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            oe      <= 8'h00;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            oe <= 8'b0001_1000;
            s1 <= stb;
            s2 <= s1;
            case (state)
                IDLE: begin
                    if (s2) begin
                        ack   <= 1'b1;
                        state <= EXEC;
                        if (is_addr) begin
                            addr <= ui_in;
                            err  <= 1'b0;
                        end else if (!rnw) begin
                            if (in_range) begin
                                regs[idx] <= ui_in;
                                err       <= 1'b0;
`ifdef TT_PIN_REG_AUTOINC_EN
                                addr      <= addr_inc;
`endif
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            if (in_range) begin
                                rd_data <= regs[idx];
                                err     <= 1'b0;
`ifdef TT_PIN_REG_AUTOINC_EN
                                addr    <= addr_inc;
`endif
                            end else if (addr == STATUS_ADDR) begin
                                rd_data <= status_in;
                                err     <= 1'b0;
                            end else begin
                                rd_data <= 8'h00;
                                err     <= 1'b1;
                            end
                        end
                    end
                end
                EXEC: begin
                    state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!s2) begin
                        ack   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tt_pin_reg_responder.md
Name: tt_pin_reg_responder

Overview:
- Chip-side responder for the host-driven pin protocol on the Tiny Tapeout user pins.
- External host (bench or RP2040) drives address, data and strobe on ui_in/uio_in. This block decodes each transfer and updates a bank of 8-bit trim/config registers for the analog macros, or returns read data on uo_out.
- Four-phase strobe/ack handshake, so a slow, asynchronous host works at any clk rate.

Parameters:
- NREGS, 8, number of read/write trim registers (1..16); addresses 0..NREGS-1.
- STATUS_ADDR, 8'hFF, address of the read-only status byte.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- ui_in  input  8  host data/address byte
- uio_in  input  8  [0]=stb, [1]=rnw (1=read), [2]=is_addr (1=address phase); [7:3] ignored
- uo_out  output  8  read data
- uio_out  output  8  [3]=ack, [4]=err; all other bits 0
- uio_oe  output  8  pad output enables
- status_in  input  8  live status byte from the analog side, readable at STATUS_ADDR
- trim_out  output  NREGS*8  flattened register bank; reg k occupies bits [8k+7:8k]

Behaviour:
- Reset values (rst=1 at a clk edge): all regs 0, addr 0, uo_out 0, ack 0, err 0, uio_oe 8'h00, FSM in IDLE, both sync flops 0.
- First clk edge with rst=0: uio_oe becomes 8'b0001_1000 and stays constant thereafter.
- stb passes through a 2-flop synchronizer (s1, s2).
- rnw, is_addr and ui_in are sampled in EXEC only. The host holds them stable while stb=1.
- FSM states:
  - IDLE: if s2=1, go to EXEC.
  - EXEC: lasts 1 cycle. Performs the action, sets ack=1, goes to WAIT_LO.
  - WAIT_LO: when s2=0, ack=0, go to IDLE.
- Latency: if s1 captures stb=1 at edge N, ack is high after edge N+2. If s1 captures stb=0 at edge M, ack is low after edge M+2.
- Action in EXEC:
  - is_addr=1: addr <= ui_in, err <= 0. rnw is ignored.
  - is_addr=0, rnw=0 (write):
    - addr < NREGS: reg[addr] <= ui_in, err <= 0.
    - otherwise: write dropped, err <= 1. This includes STATUS_ADDR, which is read-only.
  - is_addr=0, rnw=1 (read):
    - addr < NREGS: uo_out <= reg[addr], err <= 0.
    - addr == STATUS_ADDR: uo_out <= status_in, sampled in the EXEC cycle, err <= 0.
    - otherwise: uo_out <= 8'h00, err <= 1.
- uo_out holds its value until the next read. Address and write phases do not change it.
- err holds until the next EXEC.
- A stb pulse shorter than 2 clk periods may be missed. Host protocol forbids it; no recovery logic.
- Reset while in EXEC or WAIT_LO:
  - returns to the IDLE state and zeroes everything, including ack.
  - If stb is still high after reset, it is treated as a new transfer: IDLE sees s2=1 and executes again. This is a host protocol violation, and the behaviour is accepted.
- trim_out changes only on the EXEC cycle of a valid write. It is glitch-free, being driven directly from the registers.

Optional Feature:
- Macro: TT_PIN_REG_AUTOINC_EN.
- Defined:
  - After every data-phase EXEC (read or write) with addr < NREGS, addr <= addr+1.
  - Wraps from NREGS-1 to 0.
  - No increment on error or on STATUS_ADDR.
- Undefined: addr changes only in an address phase.

Test Plan:
- Reset then idle: rst high 2 cycles, release -> uo_out=0, ack=0, err=0, uio_oe=8'h18, trim_out=0.
- Write then read back: addr phase 8'h03, write 8'hA5, addr 8'h03, read -> trim_out[31:24]=8'hA5, uo_out=8'hA5, err=0. Ack rises 2 edges after s1 samples stb high, falls 2 edges after s1 samples stb low.
- Status read: status_in=8'h5C, addr 8'hFF, read -> uo_out=8'h5C, err=0. Write 8'h11 to 8'hFF -> err=1, no trim_out change.
- Out of range: addr 8'h20, read -> uo_out=8'h00, err=1. Following valid addr phase -> err=0.
- Reset mid-transfer: write 8'h77 to reg 1, raise stb, assert rst in WAIT_LO -> ack=0, trim_out=0 after that edge.
- AUTOINC (macro defined): addr 8'h06, write 8'h11, 8'h22, 8'h33 -> reg6=8'h11, reg7=8'h22, reg0=8'h33 (wrap with NREGS=8).
